// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.sv
// Programmable integer clock divider feeding the clock inverter/buffer tree.
// Ratio and enable are only sampled at idle or on the period wrap edge, so Q never produces a runt pulse.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  output logic             Q,
  output logic             TC,
  output logic             LD
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] nreg, nreg_nxt;
  logic [WIDTH-1:0] neff, cnt_inc, half, last;
  logic             wrap;
  logic             q_reg, q_nxt;
  logic             tc_reg, tc_nxt;
  logic             ld_reg, ld_nxt;

  assign neff    = (DIV < TWO) ? TWO : DIV;
  assign cnt_inc = cnt + ONE;
  assign half    = nreg >> 1;
  assign last    = nreg - ONE;
  assign wrap    = (cnt == last);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      nreg   <= TWO;
      q_reg  <= 1'b0;
      tc_reg <= 1'b0;
      ld_reg <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      nreg   <= nreg_nxt;
      q_reg  <= q_nxt;
      tc_reg <= tc_nxt;
      ld_reg <= ld_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    nreg_nxt  = nreg;
    unique case (state)
      IDLE: begin
        if (EN) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          nreg_nxt  = neff;
        end
      end
      RUN: begin
        if (!wrap) begin
          cnt_nxt = cnt_inc;
        end else if (EN) begin
          cnt_nxt  = '0;
          nreg_nxt = neff;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Q is high for the first floor(N/2) counts of a period, so the low phase gets the extra cycle on odd N.
  always_comb begin
    q_nxt  = 1'b0;
    tc_nxt = 1'b0;
    ld_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (EN) begin
          q_nxt  = 1'b1;
          ld_nxt = (neff != nreg);
        end
      end
      RUN: begin
        if (!wrap) begin
          q_nxt  = (cnt_inc < half);
          tc_nxt = (cnt_inc == last);
        end else if (EN) begin
          q_nxt  = 1'b1;
          ld_nxt = (neff != nreg);
        end
      end
      default: begin
        q_nxt = 1'b0;
      end
    endcase
  end

  assign Q  = q_reg;
  assign TC = tc_reg;
  assign LD = ld_reg;

`ifndef FUNCTIONAL
  specify
    (CLK => Q)  = (1.0, 1.0);
    (CLK => TC) = (1.0, 1.0);
    (CLK => LD) = (1.0, 1.0);
    (RST => Q)  = (1.0, 1.0);
    $setuphold(posedge CLK, EN, 0, 0);
    $setuphold(posedge CLK, DIV, 0, 0);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.sv
// Directed bench for the programmable clock divider: each task runs one scenario
// and compares Q/TC/LD against hand-computed per-edge tables.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN  = 1'b0;
  logic [3:0] DIV = 4'd4;
  logic       Q, TC, LD;

  int checks = 0;
  int errors = 0;

  gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog #(.WIDTH(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .EN (EN),
    .DIV(DIV),
    .Q  (Q),
    .TC (TC),
    .LD (LD)
  );

  always #5 CLK = ~CLK;

  // Outputs are sampled 1 time unit after each rising edge; inputs also change there.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    EN  = 1'b0;
    tick();
    tick();
    checks++; if (Q !== 1'b0)  begin errors++; $display("[TB] FAIL reset Q got %b exp 0", Q); end
    checks++; if (TC !== 1'b0) begin errors++; $display("[TB] FAIL reset TC got %b exp 0", TC); end
    checks++; if (LD !== 1'b0) begin errors++; $display("[TB] FAIL reset LD got %b exp 0", LD); end
    RST = 1'b0;
    tick();
    checks++; if (Q !== 1'b0)  begin errors++; $display("[TB] FAIL idle Q got %b exp 0", Q); end
    checks++; if (TC !== 1'b0) begin errors++; $display("[TB] FAIL idle TC got %b exp 0", TC); end
  endtask

  task automatic test_div4();
    DIV = 4'd4;
    EN  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (Q !== ((i % 4) < 2)) begin errors++; $display("[TB] FAIL div4[%0d] Q got %b exp %b", i, Q, ((i % 4) < 2)); end
      checks++; if (TC !== ((i % 4) == 3)) begin errors++; $display("[TB] FAIL div4[%0d] TC got %b exp %b", i, TC, ((i % 4) == 3)); end
      checks++; if (LD !== (i == 0)) begin errors++; $display("[TB] FAIL div4[%0d] LD got %b exp %b", i, LD, (i == 0)); end
    end
    EN = 1'b0;
    tick();
    checks++; if (Q !== 1'b0)  begin errors++; $display("[TB] FAIL div4 stop Q got %b exp 0", Q); end
    checks++; if (TC !== 1'b0) begin errors++; $display("[TB] FAIL div4 stop TC got %b exp 0", TC); end
  endtask

  task automatic test_ratio_change();
    logic [0:14] eq  = 15'b100110001100000;
    logic [0:14] etc = 15'b001000010000100;
    logic [0:14] eld = 15'b100100000000000;
    DIV = 4'd3;
    EN  = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++; if (Q !== eq[i])   begin errors++; $display("[TB] FAIL ratio[%0d] Q got %b exp %b", i, Q, eq[i]); end
      checks++; if (TC !== etc[i]) begin errors++; $display("[TB] FAIL ratio[%0d] TC got %b exp %b", i, TC, etc[i]); end
      checks++; if (LD !== eld[i]) begin errors++; $display("[TB] FAIL ratio[%0d] LD got %b exp %b", i, LD, eld[i]); end
      if (i == 1)  DIV = 4'd5;
      if (i == 8)  EN  = 1'b0;
      if (i == 12) DIV = 4'd7;
    end
  endtask

  task automatic test_div0_1();
    logic [0:10] eq  = 11'b10101010100;
    logic [0:10] etc = 11'b01010101010;
    DIV = 4'd2;
    EN  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++; if (Q !== eq[i])   begin errors++; $display("[TB] FAIL div01[%0d] Q got %b exp %b", i, Q, eq[i]); end
      checks++; if (TC !== etc[i]) begin errors++; $display("[TB] FAIL div01[%0d] TC got %b exp %b", i, TC, etc[i]); end
      checks++; if (LD !== (i == 0)) begin errors++; $display("[TB] FAIL div01[%0d] LD got %b exp %b", i, LD, (i == 0)); end
      if (i == 0) DIV = 4'd0;
      if (i == 4) DIV = 4'd1;
      if (i == 8) EN  = 1'b0;
    end
  endtask

  task automatic test_en_drop();
    logic [0:10] eq  = 11'b11100000111;
    logic [0:10] etc = 11'b00000100000;
    DIV = 4'd6;
    EN  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++; if (Q !== eq[i])   begin errors++; $display("[TB] FAIL endrop[%0d] Q got %b exp %b", i, Q, eq[i]); end
      checks++; if (TC !== etc[i]) begin errors++; $display("[TB] FAIL endrop[%0d] TC got %b exp %b", i, TC, etc[i]); end
      checks++; if (LD !== (i == 0)) begin errors++; $display("[TB] FAIL endrop[%0d] LD got %b exp %b", i, LD, (i == 0)); end
      if (i == 1) EN = 1'b0;
      if (i == 5) DIV = 4'd9;
      if (i == 7) begin
        DIV = 4'd6;
        EN  = 1'b1;
      end
    end
  endtask

  task automatic test_async_reset();
    #3;
    RST = 1'b1;
    #1;
    checks++; if (Q !== 1'b0)  begin errors++; $display("[TB] FAIL arst Q got %b exp 0", Q); end
    checks++; if (TC !== 1'b0) begin errors++; $display("[TB] FAIL arst TC got %b exp 0", TC); end
    checks++; if (LD !== 1'b0) begin errors++; $display("[TB] FAIL arst LD got %b exp 0", LD); end
    tick();
    checks++; if (Q !== 1'b0)  begin errors++; $display("[TB] FAIL arst hold Q got %b exp 0", Q); end
    #2;
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (Q !== (i < 3))   begin errors++; $display("[TB] FAIL arst[%0d] Q got %b exp %b", i, Q, (i < 3)); end
      checks++; if (TC !== (i == 5)) begin errors++; $display("[TB] FAIL arst[%0d] TC got %b exp %b", i, TC, (i == 5)); end
      checks++; if (LD !== (i == 0)) begin errors++; $display("[TB] FAIL arst[%0d] LD got %b exp %b", i, LD, (i == 0)); end
    end
    EN = 1'b0;
    tick();
    checks++; if (Q !== 1'b0)  begin errors++; $display("[TB] FAIL arst stop Q got %b exp 0", Q); end
    checks++; if (TC !== 1'b0) begin errors++; $display("[TB] FAIL arst stop TC got %b exp 0", TC); end
  endtask

  task automatic test_div15();
    DIV = 4'd15;
    EN  = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      checks++; if (Q !== ((i % 15) < 7))   begin errors++; $display("[TB] FAIL div15[%0d] Q got %b exp %b", i, Q, ((i % 15) < 7)); end
      checks++; if (TC !== ((i % 15) == 14)) begin errors++; $display("[TB] FAIL div15[%0d] TC got %b exp %b", i, TC, ((i % 15) == 14)); end
      checks++; if (LD !== (i == 0))         begin errors++; $display("[TB] FAIL div15[%0d] LD got %b exp %b", i, LD, (i == 0)); end
    end
    EN = 1'b0;
    tick();
    checks++; if (Q !== 1'b0)  begin errors++; $display("[TB] FAIL div15 stop Q got %b exp 0", Q); end
    checks++; if (TC !== 1'b0) begin errors++; $display("[TB] FAIL div15 stop TC got %b exp 0", TC); end
    checks++; if (LD !== 1'b0) begin errors++; $display("[TB] FAIL div15 stop LD got %b exp 0", LD); end
    tick();
    checks++; if (Q !== 1'b0)  begin errors++; $display("[TB] FAIL div15 idle Q got %b exp 0", Q); end
  endtask

  initial begin
    test_reset();
    test_div4();
    test_ratio_change();
    test_div0_1();
    test_en_drop();
    test_async_reset();
    test_div15();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
